// File: rtl/pht_ctrl_pkg.sv
// Shared definitions for the pattern-history-table controller: default widths,
// counter limits, arbitration state encoding and resolution-queue entry width.
package pht_ctrl_pkg;

    localparam int PHT_IDX_W_DEF = 10;
    localparam int PHT_CNT_W_DEF = 2;
    localparam int PHT_CNT_MAX_DEF = (1 << PHT_CNT_W_DEF) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    // A queued resolution is {idx, taken}.
    function automatic int entry_w(input int idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/pht_ctrl_if.sv
// Fetch lookup, execute resolution and table port signals of pht_ctrl.
// The controller uses the slave modport; the surrounding pipeline/table the master.
interface pht_ctrl_if
    import pht_ctrl_pkg::*;
#(
    parameter int IDX_W   = PHT_IDX_W_DEF,
    parameter int CNT_W   = PHT_CNT_W_DEF,
    parameter int PC_W    = 32,
    parameter int Q_DEPTH = 4
);
    logic                       lk_valid;
    logic [PC_W-1:0]            lk_pc;
    logic                       lk_ready;
    logic                       lk_taken;
    logic [IDX_W-1:0]           lk_idx;

    logic                       rs_valid;
    logic                       rs_ready;
    logic [IDX_W-1:0]           rs_idx;
    logic                       rs_taken;

    logic [IDX_W-1:0]           pht_addr;
    logic                       pht_wr_en;
    logic [CNT_W-1:0]           pht_wr_data;
    logic [CNT_W-1:0]           pht_rd_data;

    logic [$clog2(Q_DEPTH):0]   q_count;

    modport master (
        output lk_valid, lk_pc, rs_valid, rs_idx, rs_taken, pht_rd_data,
        input  lk_ready, lk_taken, lk_idx, rs_ready, pht_addr, pht_wr_en,
        input  pht_wr_data, q_count
    );

    modport slave (
        input  lk_valid, lk_pc, rs_valid, rs_idx, rs_taken, pht_rd_data,
        output lk_ready, lk_taken, lk_idx, rs_ready, pht_addr, pht_wr_en,
        output pht_wr_data, q_count
    );

endinterface

// File: rtl/pht_upd_fifo.sv
// Synchronous resolution queue: DEPTH entries, pointers carry one extra wrap bit
// so occupancy is simply wr_ptr - rd_ptr. Caller never pushes when full or pops when empty.
module pht_upd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/pht_ctrl.sv
// Pattern-history-table port arbiter: same-cycle fetch lookups versus queued
// saturating counter updates, with starvation-forced drains. PHT_CTRL_GSHARE_EN adds the GHR.
module pht_ctrl
    import pht_ctrl_pkg::*;
#(
    parameter int IDX_W      = PHT_IDX_W_DEF,
    parameter int CNT_W      = PHT_CNT_W_DEF,
    parameter int PC_W       = 32,
    parameter int Q_DEPTH    = 4,
    parameter int STARVE_LIM = 8
) (
    input logic        clk,
    input logic        reset,
    pht_ctrl_if.slave  bus
);
    localparam int CW = $clog2(Q_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int EW = entry_w(IDX_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0]    Q_ONE   = 1;
    localparam logic [CW-1:0]    Q_FULL  = CW'(Q_DEPTH);
    localparam logic [SW-1:0]    S_ONE   = 1;
    localparam logic [SW-1:0]    S_LIM   = SW'(STARVE_LIM);

    arb_state_e        state_q;
    logic              lk_ready_q;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CW-1:0]     q_count, q_count_d;
    logic [EW-1:0]     head;
    logic [IDX_W-1:0]  lookup_idx;
    logic              q_full, push, drain;
    logic              unused_pc;

    pht_upd_fifo #(.W(EW), .DEPTH(Q_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.rs_idx, bus.rs_taken}),
        .pop       (drain),
        .head      (head),
        .count     (q_count)
    );

`ifdef PHT_CTRL_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    always_ff @(posedge clk) begin
        if (reset)     ghr_q <= '0;
        else if (push) ghr_q <= {ghr_q[IDX_W-2:0], bus.rs_taken};
    end

    assign lookup_idx = bus.lk_pc[IDX_W+1:2] ^ ghr_q;
`else
    assign lookup_idx = bus.lk_pc[IDX_W+1:2];
`endif

    assign unused_pc = ^{bus.lk_pc[PC_W-1:IDX_W+2], bus.lk_pc[1:0]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        q_full    = (q_count == Q_FULL);
        push      = bus.rs_valid && !q_full;
        drain     = !reset && ((state_q == ST_FORCE) ||
                               (state_q == ST_PEND && !bus.lk_valid));
        q_count_d = q_count;
        case ({push, drain})
            2'b10:   q_count_d = q_count + Q_ONE;
            2'b01:   q_count_d = q_count - Q_ONE;
            default: q_count_d = q_count;
        endcase

        starve_d = starve_q;
        if (state_q == ST_FORCE || drain) starve_d = '0;
        else if (state_q == ST_PEND && q_full) starve_d = starve_q + S_ONE;

        bus.pht_wr_data = bus.pht_rd_data;
        if (head[0] && bus.pht_rd_data != CNT_MAX)
            bus.pht_wr_data = bus.pht_rd_data + CNT_ONE;
        else if (!head[0] && bus.pht_rd_data != '0)
            bus.pht_wr_data = bus.pht_rd_data - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            lk_ready_q <= 1'b1;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                ST_IDLE: if (push) state_q <= ST_PEND;
                ST_PEND: begin
                    if (q_count_d == '0) begin
                        state_q <= ST_IDLE;
                    end else if (starve_d == S_LIM) begin
                        state_q    <= ST_FORCE;
                        lk_ready_q <= 1'b0;
                    end
                end
                ST_FORCE: begin
                    state_q    <= (q_count_d == '0) ? ST_IDLE : ST_PEND;
                    lk_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    lk_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pht_addr  = drain ? head[EW-1:1] : lookup_idx;
    assign bus.pht_wr_en = drain;
    assign bus.lk_ready  = lk_ready_q;
    assign bus.lk_taken  = bus.pht_rd_data[CNT_W-1];
    assign bus.lk_idx    = lookup_idx;
    assign bus.rs_ready  = !q_full;
    assign bus.q_count   = q_count;

endmodule
